alarm_clk_pio_ext: RTL and testbench

ALARM_CLK_PIO_EXT -- requirements
Module: alarm_clk_pio_ext

---
 rtl/alarm_clk_pio_ext_pkg.sv | 25 ++
 rtl/alarm_clk_pio_ext_sync_edge.sv | 56 +++++
 rtl/alarm_clk_pio_ext.sv | 111 +++++++++++
 tb/tb_alarm_clk_pio_ext.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clk_pio_ext_pkg.sv
// ---------------------------------------------------------------------------
// alarm_clk_pio_ext_pkg
// Shared constants for the alarm-clock PIO block: Avalon-MM word addresses,
// edge-capture mode encodings and the bus data width.
// Optional feature macro used by the top level: ALARM_CLK_PIO_BITSET_EN
// (adds the output bit-set / bit-clear addresses).
// ---------------------------------------------------------------------------
package alarm_clk_pio_ext_pkg;

  localparam int DATA_WIDTH_MAX = 32;

  // Register map (word addresses)
  localparam logic [2:0] ADDR_DATA = 3'd0;  // synchronized inputs, read-only
  localparam logic [2:0] ADDR_OUT  = 3'd1;  // output register
  localparam logic [2:0] ADDR_MASK = 3'd2;  // irq mask
  localparam logic [2:0] ADDR_EDGE = 3'd3;  // edge capture, write-1-to-clear
  localparam logic [2:0] ADDR_SET  = 3'd4;  // output bit-set (optional)
  localparam logic [2:0] ADDR_CLR  = 3'd5;  // output bit-clear (optional)

  // Edge capture modes
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/alarm_clk_pio_ext_sync_edge.sv
// ---------------------------------------------------------------------------
// alarm_clk_pio_sync_edge
// Per-bit synchronizer chain followed by a previous-value register and an
// edge detector.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   din       in   WIDTH asynchronous inputs
//   sync_out  out  WIDTH synchronized inputs (last chain stage)
//   edge_out  out  WIDTH per-bit edge pulses, one cycle wide, per EDGE_TYPE
// ---------------------------------------------------------------------------
module alarm_clk_pio_sync_edge
  import alarm_clk_pio_ext_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_out
);

  // Whole chain kept in one flat vector: stage 0 in the low WIDTH bits,
  // the oldest stage in the high WIDTH bits.
  logic [STAGES*WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]        prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[(STAGES-1)*WIDTH-1:0], din};
      prev_reg  <= sync_out;
    end
  end

  assign sync_out = chain_reg[STAGES*WIDTH-1 -: WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
        assign edge_out[gi] = ~sync_out[gi] & prev_reg[gi];
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_out[gi] = sync_out[gi] ^ prev_reg[gi];
      end else begin : g_rise
        assign edge_out[gi] = sync_out[gi] & ~prev_reg[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/alarm_clk_pio_ext.sv
// ---------------------------------------------------------------------------
// alarm_clk_pio_ext
// Avalon-MM parallel I/O port for the alarm clock: output register, input
// synchronizer with edge capture, irq mask and level interrupt.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address[2:0]            word address
//   chipselect, write_n     write strobe = chipselect & ~write_n
//   writedata[31:0]         write data
//   readdata[31:0]          zero-latency combinational read data
//   in_port[IN_WIDTH-1:0]   asynchronous external inputs
//   out_port[OUT_WIDTH-1:0] output register drive
//   irq                     OR of (capture & mask)
// Optional macro ALARM_CLK_PIO_BITSET_EN: address 4 sets and address 5 clears
// output bits where writedata is 1; without it those addresses are unmapped.
// ---------------------------------------------------------------------------
module alarm_clk_pio_ext
  import alarm_clk_pio_ext_pkg::*;
#(
  parameter int                 OUT_WIDTH   = 8,
  parameter int                 IN_WIDTH    = 8,
  parameter int                 EDGE_TYPE   = EDGE_RISING,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [DATA_WIDTH_MAX-1:0] writedata,
  output logic [DATA_WIDTH_MAX-1:0] readdata,
  input  logic [IN_WIDTH-1:0]       in_port,
  output logic [OUT_WIDTH-1:0]      out_port,
  output logic                      irq
);

  logic                 strobe;
  logic [OUT_WIDTH-1:0] out_reg, out_next;
  logic [IN_WIDTH-1:0]  mask_reg, mask_next;
  logic [IN_WIDTH-1:0]  capture_reg, capture_next;
  logic [IN_WIDTH-1:0]  sync_value;
  logic [IN_WIDTH-1:0]  edge_hit;
  logic [OUT_WIDTH-1:0] wdata_out;
  logic [IN_WIDTH-1:0]  wdata_in;
  logic                 unused_wdata;

  assign strobe    = chipselect & ~write_n;
  assign wdata_out = writedata[OUT_WIDTH-1:0];
  assign wdata_in  = writedata[IN_WIDTH-1:0];
  // Bits above the register widths are intentionally dropped.
  assign unused_wdata = ^writedata;

  alarm_clk_pio_sync_edge #(
    .WIDTH     (IN_WIDTH),
    .STAGES    (SYNC_STAGES),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (in_port),
    .sync_out (sync_value),
    .edge_out (edge_hit)
  );

  always_comb begin
    out_next     = out_reg;
    mask_next    = mask_reg;
    // New edges are OR-ed in after any clear so a same-cycle edge survives.
    capture_next = capture_reg | edge_hit;
    if (strobe) begin
      case (address)
        ADDR_OUT:  out_next     = wdata_out;
        ADDR_MASK: mask_next    = wdata_in;
        ADDR_EDGE: capture_next = (capture_reg & ~wdata_in) | edge_hit;
`ifdef ALARM_CLK_PIO_BITSET_EN
        ADDR_SET:  out_next     = out_reg | wdata_out;
        ADDR_CLR:  out_next     = out_reg & ~wdata_out;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg     <= RESET_VALUE;
      mask_reg    <= '0;
      capture_reg <= '0;
    end else begin
      out_reg     <= out_next;
      mask_reg    <= mask_next;
      capture_reg <= capture_next;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[IN_WIDTH-1:0]  = sync_value;
      ADDR_OUT:  readdata[OUT_WIDTH-1:0] = out_reg;
      ADDR_MASK: readdata[IN_WIDTH-1:0]  = mask_reg;
      ADDR_EDGE: readdata[IN_WIDTH-1:0]  = capture_reg;
      default:   readdata = '0;
    endcase
  end

  assign out_port = out_reg;
  assign irq      = |(capture_reg & mask_reg);

endmodule

// File: tb/tb_alarm_clk_pio_ext.sv
// ---------------------------------------------------------------------------
// tb_alarm_clk_pio_ext
// Three instances (rising/2 stages, falling/2 stages, any/3 stages) share one
// bus and one in_port. A reference model keeps the in_port history as a
// delay line and derives synchronized value, edges, capture, mask, output and
// irq from it; directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_alarm_clk_pio_ext;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd     [N];
  logic [7:0]  outp   [N];
  logic        irq_w  [N];

  always #5 clk = ~clk;

  alarm_clk_pio_ext #(.OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(0),
                      .RESET_VALUE(8'hA5), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_port), .out_port(outp[0]), .irq(irq_w[0]));

  alarm_clk_pio_ext #(.OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(1),
                      .RESET_VALUE(8'hA5), .SYNC_STAGES(2)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_port), .out_port(outp[1]), .irq(irq_w[1]));

  alarm_clk_pio_ext #(.OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(2),
                      .RESET_VALUE(8'hA5), .SYNC_STAGES(3)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_port), .out_port(outp[2]), .irq(irq_w[2]));

  // ---------------- reference model ----------------
  logic [7:0] hist   [5];   // hist[j] = in_port sampled j+1 clock edges ago (j=0 newest)
  logic [7:0] m_out  [N];
  logic [7:0] m_mask [N];
  logic [7:0] m_cap  [N];
  int checks = 0;
  int passes = 0;

  function automatic int stages_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 5; j++) hist[j] = 8'h00;
    for (int i = 0; i < N; i++) begin
      m_out[i]  = 8'hA5;
      m_mask[i] = 8'h00;
      m_cap[i]  = 8'h00;
    end
  endtask

  // Synchronized value is the input seen S edges ago; previous value S+1 ago.
  function automatic logic [7:0] edges_of(int i);
    logic [7:0] s, p;
    s = hist[stages_of(i)-1];
    p = hist[stages_of(i)];
    case (i)
      0:       return s & ~p;
      1:       return ~s & p;
      default: return s ^ p;
    endcase
  endfunction

  task automatic model_step();
    logic       wr;
    logic [7:0] e, wd;
    wr = chipselect & ~write_n;
    wd = writedata[7:0];
    for (int i = 0; i < N; i++) begin
      e = edges_of(i);
      if (wr) begin
        case (address)
          3'd1: m_out[i]  = wd;
          3'd2: m_mask[i] = wd;
          3'd3: m_cap[i]  = m_cap[i] & ~wd;
`ifdef ALARM_CLK_PIO_BITSET_EN
          3'd4: m_out[i]  = m_out[i] | wd;
          3'd5: m_out[i]  = m_out[i] & ~wd;
`endif
          default: ;
        endcase
      end
      m_cap[i] = m_cap[i] | e;
    end
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = in_port;
  endtask

  function automatic logic [31:0] exp_rd(int i, logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, hist[stages_of(i)-1]};
      3'd1:    return {24'h0, m_out[i]};
      3'd2:    return {24'h0, m_mask[i]};
      3'd3:    return {24'h0, m_cap[i]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("out%0d", i), {24'h0, outp[i]}, {24'h0, m_out[i]});
      check_val($sformatf("irq%0d", i), {31'h0, irq_w[i]}, {31'h0, |(m_cap[i] & m_mask[i])});
      check_val($sformatf("rd%0d_a%0d", i, address), rd[i], exp_rd(i, address));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic cs, logic wn, logic [2:0] a, logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    step();
    drive(1'b0, 1'b1, a, 32'h0);
  endtask

  logic [7:0] exp_set, exp_clr;

  initial begin
    reset_n = 1'b0;
    in_port = 8'h00;
    drive(1'b0, 1'b1, 3'd2, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_val("rst_out", {24'h0, outp[0]}, 32'h0000_00A5);
    check_val("rst_irq", {31'h0, irq_w[0]}, 32'h0);
    check_val("rst_mask", rd[0], 32'h0);
    address = 3'd3;
    #1;
    check_val("rst_cap", rd[0], 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Output register write, upper data bits ignored
    wr(3'd1, 32'hFFFF_FF3C);
    check_val("out_3c", {24'h0, outp[0]}, 32'h0000_003C);
    check_val("rd_out_3c", rd[0], 32'h0000_003C);

    // Rising capture latency and W1C
    wr(3'd2, 32'h0000_0001);
    in_port = 8'h01;
    steps(2);
    check_val("lat_k1_irq", {31'h0, irq_w[0]}, 32'h0);
    step();
    check_val("lat_k2_irq", {31'h0, irq_w[0]}, 32'h1);
    wr(3'd3, 32'h0000_0001);
    check_val("w1c_irq", {31'h0, irq_w[0]}, 32'h0);
    check_val("w1c_cap", rd[0], 32'h0);

    // Edge and W1C in the same cycle: set wins
    in_port = 8'h00;
    steps(4);
    in_port = 8'h01;
    steps(2);
    wr(3'd3, 32'h0000_0001);
    check_val("setwins_irq", {31'h0, irq_w[0]}, 32'h1);
    check_val("setwins_cap", rd[0], 32'h1);

    // Any-edge pulse with mask off, then mask on
    in_port = 8'h00;
    steps(5);
    wr(3'd3, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0000);
    in_port = 8'h08;
    steps(4);
    in_port = 8'h00;
    steps(6);
    drive(1'b0, 1'b1, 3'd3, 32'h0);
    #1;
    check_val("any_cap", rd[2], 32'h0000_0008);
    check_val("any_irq_off", {31'h0, irq_w[2]}, 32'h0);
    wr(3'd2, 32'h0000_0008);
    check_val("any_irq_on", {31'h0, irq_w[2]}, 32'h1);

    // Bit set / clear
`ifdef ALARM_CLK_PIO_BITSET_EN
    exp_set = 8'hFF;
    exp_clr = 8'hFC;
`else
    exp_set = 8'h0F;
    exp_clr = 8'h0F;
`endif
    wr(3'd1, 32'h0000_000F);
    wr(3'd4, 32'h0000_00F0);
    check_val("bitset", {24'h0, outp[0]}, {24'h0, exp_set});
    wr(3'd5, 32'h0000_0003);
    check_val("bitclr", {24'h0, outp[0]}, {24'h0, exp_clr});

    // Asynchronous reset mid-operation, input held high through release
    in_port = 8'h01;
    address = 3'd3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_out", {24'h0, outp[0]}, 32'h0000_00A5);
    check_val("arst_cap", rd[0], 32'h0);
    check_val("arst_irq", {31'h0, irq_w[0]}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    steps(2);
    check_val("rel_cap_early", rd[0], 32'h0);
    step();
    check_val("rel_cap", rd[0], 32'h1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0)
        in_port = in_port ^ (8'($urandom) & 8'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
